// File: rtl/move_sequencer_if.sv
// Button/vblank/game-status inputs and game command outputs of move_sequencer.
// master = sequencer side, slave = board/game side.
interface move_sequencer_if;
   logic [4:0] btn_n;
   logic       vblank;
   logic       game_busy;
   logic       game_over;
   logic       start;
   logic       mov_left;
   logic       mov_right;
   logic       mov_up;
   logic       mov_down;
   logic       cmd_pending;
   logic [7:0] drop_cnt;

   modport master (
      input  btn_n, vblank, game_busy, game_over,
      output start, mov_left, mov_right, mov_up, mov_down, cmd_pending, drop_cnt
   );

   modport slave (
      output btn_n, vblank, game_busy, game_over,
      input  start, mov_left, mov_right, mov_up, mov_down, cmd_pending, drop_cnt
   );
endinterface

// File: rtl/move_sequencer.sv
// Purpose: debounced, arbitrated button presses -> one game command pulse issued in vblank.
// Latency: press event 2+DEBOUNCE_CYCLES cycles after raw edge; pulse 1 cycle after vblank rise.
// Backpressure: one command held at a time; events arriving while pending are dropped and counted.
module move_sequencer #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18,
   parameter int ACK_TIMEOUT     = 1024
) (
   input logic              clk_25Mhz,
   input logic              _reset,
   move_sequencer_if.master bus
);
   localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_VB, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_RELEASE
   } state_t;

   // Bit layout everywhere: [4]=start [3]=down [2]=up [1]=right [0]=left
   logic [4:0]       sync1, sync2;
   logic [4:0]       sync_pr;
   logic [4:0]       db_pr;
   logic [4:0]       press_evt;
   logic [CNT_W-1:0] db_cnt [5];

   state_t           state;
   logic [4:0]       cmd_q;
   logic [ACK_W-1:0] ack_cnt;
   logic             vb_q;
   logic             start_q, left_q, right_q, up_q, down_q, pending_q;
   logic [7:0]       drop_q;

   logic [4:0]       eligible, grant;
   logic [2:0]       n_evt, n_drop;
   logic [8:0]       drop_sum;
   logic             vb_rise;

   assign sync_pr = ~sync2;
   assign vb_rise = bus.vblank & ~vb_q;

   always_ff @(posedge clk_25Mhz or negedge _reset) begin
      if (!_reset) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= bus.btn_n;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk_25Mhz or negedge _reset) begin
      if (!_reset) begin
         db_pr     <= '0;
         press_evt <= '0;
         for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
      end else begin
         press_evt <= '0;
         for (int i = 0; i < 5; i++) begin
            if (sync_pr[i] == db_pr[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               db_cnt[i]    <= '0;
               db_pr[i]     <= sync_pr[i];
               press_evt[i] <= sync_pr[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Only one event can win in IDLE; start is the only command allowed once the game is over.
   always_comb begin
      n_evt = '0;
      for (int i = 0; i < 5; i++) n_evt = n_evt + {2'b00, press_evt[i]};
      eligible = '0;
      if (state == S_IDLE) eligible = bus.game_over ? (press_evt & 5'b10000) : press_evt;
      grant = '0;
      if      (eligible[4]) grant = 5'b10000;
      else if (eligible[0]) grant = 5'b00001;
      else if (eligible[1]) grant = 5'b00010;
      else if (eligible[2]) grant = 5'b00100;
      else if (eligible[3]) grant = 5'b01000;
      n_drop   = n_evt - ((grant != '0) ? 3'd1 : 3'd0);
      drop_sum = {1'b0, drop_q} + {6'b0, n_drop};
   end

   always_ff @(posedge clk_25Mhz or negedge _reset) begin
      if (!_reset) begin
         state     <= S_IDLE;
         cmd_q     <= '0;
         ack_cnt   <= '0;
         vb_q      <= 1'b0;
         start_q   <= 1'b0;
         left_q    <= 1'b1;
         right_q   <= 1'b1;
         up_q      <= 1'b1;
         down_q    <= 1'b1;
         pending_q <= 1'b0;
         drop_q    <= '0;
      end else begin
         vb_q   <= bus.vblank;
         drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
         case (state)
            S_IDLE: begin
               if (grant != '0) begin
                  cmd_q     <= grant;
                  pending_q <= 1'b1;
                  state     <= S_WAIT_VB;
               end
            end
            S_WAIT_VB: begin
               if (vb_rise) begin
                  start_q <= cmd_q[4];
                  left_q  <= ~cmd_q[0];
                  right_q <= ~cmd_q[1];
                  up_q    <= ~cmd_q[2];
                  down_q  <= ~cmd_q[3];
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               start_q <= 1'b0;
               left_q  <= 1'b1;
               right_q <= 1'b1;
               up_q    <= 1'b1;
               down_q  <= 1'b1;
               ack_cnt <= '0;
               state   <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (bus.game_busy) begin
                  state <= S_WAIT_DONE;
               end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                  state <= S_RELEASE;
               end else begin
                  ack_cnt <= ack_cnt + ACK_W'(1);
               end
            end
            S_WAIT_DONE: begin
               if (!bus.game_busy) state <= S_RELEASE;
            end
            S_RELEASE: begin
               if (db_pr == '0) begin
                  pending_q <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.start       = start_q;
   assign bus.mov_left    = left_q;
   assign bus.mov_right   = right_q;
   assign bus.mov_up      = up_q;
   assign bus.mov_down    = down_q;
   assign bus.cmd_pending = pending_q;
   assign bus.drop_cnt    = drop_q;
endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with short debounce and ack timeout.
module tb_move_sequencer;
   localparam int DEB  = 8;
   localparam int ACKT = 32;
   localparam logic [4:0] IDLE_OUTS = 5'b01111; // {start, left, right, up, down}

   logic clk_25Mhz;
   logic _reset;
   int   n_checks;
   int   n_fail;
   logic [4:0] outs;

   move_sequencer_if bus ();

   move_sequencer #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W          (4),
      .ACK_TIMEOUT    (ACKT)
   ) dut (
      .clk_25Mhz(clk_25Mhz),
      ._reset   (_reset),
      .bus      (bus)
   );

   assign outs = {bus.start, bus.mov_left, bus.mov_right, bus.mov_up, bus.mov_down};

   initial begin
      clk_25Mhz = 1'b0;
      forever #20 clk_25Mhz = ~clk_25Mhz;
   end

   task automatic tick();
      @(posedge clk_25Mhz);
      #1;
   endtask

   task automatic wait_pending(input logic want, input string name);
      int n;
      n = 0;
      while (bus.cmd_pending !== want && n < 40) begin
         tick();
         n++;
      end
      n_checks++;
      if (bus.cmd_pending !== want) begin
         n_fail++;
         $display("FAIL %s: cmd_pending=%b required %b", name, bus.cmd_pending, want);
      end
   endtask

   task automatic test_reset();
      _reset = 1'b0;
      bus.btn_n = 5'h1F; bus.vblank = 1'b0; bus.game_busy = 1'b0; bus.game_over = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (outs !== IDLE_OUTS) begin n_fail++; $display("FAIL reset_outs: got %b required %b", outs, IDLE_OUTS); end
      n_checks++;
      if (bus.cmd_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b required 0", bus.cmd_pending); end
      n_checks++;
      if (bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d required 0", bus.drop_cnt); end
      _reset = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_single_press();
      logic early;
      early = 1'b0;
      bus.btn_n = 5'b11110;
      for (int k = 1; k <= DEB + 2; k++) begin
         tick();
         if (bus.cmd_pending !== 1'b0) early = 1'b1;
      end
      n_checks++;
      if (early) begin n_fail++; $display("FAIL capture_early: cmd_pending rose before %0d cycles", DEB + 3); end
      tick();
      n_checks++;
      if (bus.cmd_pending !== 1'b1) begin n_fail++; $display("FAIL capture_latency: got %b required 1", bus.cmd_pending); end
      repeat (9) tick();
      n_checks++;
      if (outs !== IDLE_OUTS) begin n_fail++; $display("FAIL left_before_vb: got %b required %b", outs, IDLE_OUTS); end
      bus.vblank = 1'b1;
      tick();
      n_checks++;
      if (outs !== 5'b00111) begin n_fail++; $display("FAIL left_pulse: got %b required 00111", outs); end
      tick();
      n_checks++;
      if (outs !== IDLE_OUTS) begin n_fail++; $display("FAIL left_pulse_width: got %b required %b", outs, IDLE_OUTS); end
      bus.vblank = 1'b0;
      repeat (3) tick();
      bus.game_busy = 1'b1;
      repeat (3) tick();
      bus.game_busy = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (bus.cmd_pending !== 1'b1) begin n_fail++; $display("FAIL held_in_release: got %b required 1", bus.cmd_pending); end
      bus.btn_n = 5'h1F;
      wait_pending(1'b0, "left_back_to_idle");
   endtask

   task automatic test_bounce();
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         bus.btn_n = ((i / 3) % 2 == 0) ? 5'b11011 : 5'b11111;
         tick();
         if (outs !== IDLE_OUTS || bus.cmd_pending !== 1'b0) bad = 1'b1;
      end
      bus.btn_n = 5'h1F;
      repeat (15) tick();
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL bounce_quiet: outputs or cmd_pending moved during bounce"); end
      n_checks++;
      if (bus.cmd_pending !== 1'b0) begin n_fail++; $display("FAIL bounce_pending: got %b required 0", bus.cmd_pending); end
      n_checks++;
      if (bus.drop_cnt !== 8'd0) begin n_fail++; $display("FAIL bounce_drop: got %0d required 0", bus.drop_cnt); end
   endtask

   task automatic test_simultaneous();
      bus.btn_n = 5'b10101;
      wait_pending(1'b1, "simul_capture");
      n_checks++;
      if (bus.drop_cnt !== 8'd1) begin n_fail++; $display("FAIL simul_drop: got %0d required 1", bus.drop_cnt); end
      bus.vblank = 1'b1;
      tick();
      n_checks++;
      if (outs !== 5'b01011) begin n_fail++; $display("FAIL simul_right_pulse: got %b required 01011", outs); end
      tick();
      bus.vblank = 1'b0;
      bus.game_busy = 1'b1;
      repeat (2) tick();
      bus.game_busy = 1'b0;
      bus.btn_n = 5'h1F;
      wait_pending(1'b0, "simul_back_to_idle");
   endtask

   task automatic test_game_over();
      logic bad;
      bad = 1'b0;
      bus.game_over = 1'b1;
      bus.btn_n = 5'b11011;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (bus.cmd_pending !== 1'b0 || outs !== IDLE_OUTS) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL over_up_ignored: up press was accepted while game over"); end
      n_checks++;
      if (bus.drop_cnt !== 8'd2) begin n_fail++; $display("FAIL over_drop: got %0d required 2", bus.drop_cnt); end
      bus.btn_n = 5'h1F;
      repeat (14) tick();
      bus.vblank = 1'b1;
      repeat (2) tick();
      bus.btn_n = 5'b01111;
      wait_pending(1'b1, "over_start_capture");
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (outs !== IDLE_OUTS) bad = 1'b1;
      end
      bus.vblank = 1'b0;
      tick();
      if (outs !== IDLE_OUTS) bad = 1'b1;
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL vb_high_on_entry: pulse issued without a new vblank rise"); end
      bus.vblank = 1'b1;
      tick();
      n_checks++;
      if (outs !== 5'b11111) begin n_fail++; $display("FAIL start_pulse: got %b required 11111", outs); end
      tick();
      n_checks++;
      if (outs !== IDLE_OUTS) begin n_fail++; $display("FAIL start_pulse_width: got %b required %b", outs, IDLE_OUTS); end
      bus.vblank = 1'b0;
      bus.game_busy = 1'b1;
      repeat (2) tick();
      bus.game_busy = 1'b0;
      bus.game_over = 1'b0;
      bus.btn_n = 5'h1F;
      wait_pending(1'b0, "start_back_to_idle");
   endtask

   task automatic test_ack_timeout();
      logic bad;
      bad = 1'b0;
      bus.btn_n = 5'b10111;
      wait_pending(1'b1, "timeout_capture");
      bus.vblank = 1'b1;
      tick();
      n_checks++;
      if (outs !== 5'b01110) begin n_fail++; $display("FAIL down_pulse: got %b required 01110", outs); end
      bus.vblank = 1'b0;
      bus.btn_n = 5'h1F;
      for (int j = 1; j <= ACKT + 1; j++) begin
         tick();
         if (bus.cmd_pending !== 1'b1 || outs !== IDLE_OUTS) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL timeout_wait: left WAIT_ACK early or pulsed again"); end
      tick();
      n_checks++;
      if (bus.cmd_pending !== 1'b0) begin n_fail++; $display("FAIL timeout_release: got %b required 0", bus.cmd_pending); end
      n_checks++;
      if (bus.drop_cnt !== 8'd2) begin n_fail++; $display("FAIL timeout_drop: got %0d required 2", bus.drop_cnt); end
   endtask

   task automatic test_drop_saturation();
      bus.btn_n = 5'b11110;
      wait_pending(1'b1, "flood_capture");
      bus.btn_n = 5'h1F;
      repeat (14) tick();
      for (int i = 0; i < 60; i++) begin
         bus.btn_n = 5'h00;
         repeat (12) tick();
         bus.btn_n = 5'h1F;
         repeat (12) tick();
         if (i == 0) begin
            n_checks++;
            if (bus.drop_cnt !== 8'd7) begin n_fail++; $display("FAIL flood_first: got %0d required 7", bus.drop_cnt); end
         end
      end
      n_checks++;
      if (bus.drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_saturate: got %0d required 255", bus.drop_cnt); end
      n_checks++;
      if (bus.cmd_pending !== 1'b1) begin n_fail++; $display("FAIL flood_pending: got %b required 1", bus.cmd_pending); end
   endtask

   task automatic test_reset_mid_command();
      #5;
      _reset = 1'b0;
      #1;
      n_checks++;
      if (outs !== IDLE_OUTS) begin n_fail++; $display("FAIL async_reset_outs: got %b required %b", outs, IDLE_OUTS); end
      n_checks++;
      if (bus.cmd_pending !== 1'b0 || bus.drop_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL async_reset_state: pending=%b drop=%0d required 0/0", bus.cmd_pending, bus.drop_cnt);
      end
      tick();
      tick();
      _reset = 1'b1;
      repeat (3) tick();
      bus.vblank = 1'b1;
      tick();
      n_checks++;
      if (outs !== IDLE_OUTS) begin n_fail++; $display("FAIL post_reset_vb: got %b required %b", outs, IDLE_OUTS); end
      tick();
      n_checks++;
      if (outs !== IDLE_OUTS || bus.cmd_pending !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: outs=%b pending=%b required %b/0", outs, bus.cmd_pending, IDLE_OUTS);
      end
      bus.vblank = 1'b0;
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single_press();
      test_bounce();
      test_simultaneous();
      test_game_over();
      test_ack_timeout();
      test_drop_saturation();
      test_reset_mid_command();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end
endmodule
